// File: rtl/ram_pkg.sv
// Shared widths and payload types for the RAM operand-fetch slice.
package ram_pkg;

    localparam int unsigned BW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned TW = 4;

    // One buffered operand pair with its request tag
    typedef struct packed {
        logic [BW-1:0] op1;
        logic [BW-1:0] op2;
        logic [TW-1:0] tag;
    } op_entry_t;

    // Issue-to-capture pipeline stage
    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        logic          fwd1;
        logic          fwd2;
        logic [BW-1:0] wb_data;
    } s1_t;

endpackage

// File: rtl/op_sync_fifo.sv
// Synchronous FIFO with exposed occupancy; head is readable while not empty.
module op_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 3,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Next-state: guarded push/pop, modulo-DEPTH pointer wrap, occupancy update
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; storage clears on reset so the idle head reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/ram_operand_fetch.sv
// Operand fetch in front of a dual-read/single-write RAM: issues both reads,
// forwards same-cycle write-back data, and buffers operand pairs for output.
module ram_operand_fetch
    import ram_pkg::*;
#(
    parameter int unsigned BW        = ram_pkg::BW,
    parameter int unsigned AW        = ram_pkg::AW,
    parameter int unsigned TW        = ram_pkg::TW,
    parameter int unsigned OUT_DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr1,
    input  logic [AW-1:0] req_addr2,
    input  logic [TW-1:0] req_tag,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [BW-1:0] wb_data,
    output logic          ram_write_en,
    output logic [BW-1:0] ram_data_in,
    output logic [AW-1:0] ram_addr_in,
    output logic          ram_read_en1,
    output logic [AW-1:0] ram_addr_out_1,
    input  logic [BW-1:0] ram_data_out1,
    output logic          ram_read_en2,
    output logic [AW-1:0] ram_addr_out_2,
    input  logic [BW-1:0] ram_data_out2,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [BW-1:0] op_data1,
    output logic [BW-1:0] op_data2,
    output logic [TW-1:0] op_tag
);

    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned EW = $bits(op_entry_t);

    s1_t           s1_q, s1_d;
    op_entry_t     push_entry;
    op_entry_t     head_entry;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          accept;
    logic          pop;

    // Write-back passes straight through to the RAM write port
    assign ram_write_en = wb_en;
    assign ram_addr_in  = wb_addr;
    assign ram_data_in  = wb_data;

    // Credit from registered state only: buffered plus in-flight must leave room
    assign req_ready = rst_n &&
                       ((CW + 1)'(fifo_count) + (CW + 1)'(s1_q.valid) < (CW + 1)'(OUT_DEPTH));
    assign accept    = req_valid && req_ready;

    assign ram_read_en1   = accept;
    assign ram_read_en2   = accept;
    assign ram_addr_out_1 = req_addr1;
    assign ram_addr_out_2 = req_addr2;

    // Issue stage: note which operands the concurrent write-back overrides
    always_comb begin
        s1_d         = '0;
        s1_d.valid   = accept;
        s1_d.tag     = req_tag;
        s1_d.fwd1    = wb_en && (wb_addr == req_addr1);
        s1_d.fwd2    = wb_en && (wb_addr == req_addr2);
        s1_d.wb_data = wb_data;
    end

    // Stage S1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // Capture stage: forwarded write-back data wins over the RAM's old data
    always_comb begin
        push_entry     = '0;
        push_entry.op1 = s1_q.fwd1 ? s1_q.wb_data : ram_data_out1;
        push_entry.op2 = s1_q.fwd2 ? s1_q.wb_data : ram_data_out2;
        push_entry.tag = s1_q.tag;
    end

    assign pop = op_valid && op_ready;

    op_sync_fifo #(
        .W     (EW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_q.valid),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign op_valid = !fifo_empty;
    assign op_data1 = head_entry.op1;
    assign op_data2 = head_entry.op2;
    assign op_tag   = head_entry.tag;

endmodule

// File: tb/tb_ram_operand_fetch.sv
// Scoreboard bench for ram_operand_fetch with a behavioural RAM attached.
module tb_ram_operand_fetch;

    localparam int unsigned BW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned TW = 4;
    localparam int unsigned NW = 32;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr1;
    logic [AW-1:0] req_addr2;
    logic [TW-1:0] req_tag;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [BW-1:0] wb_data;
    logic          ram_write_en;
    logic [BW-1:0] ram_data_in;
    logic [AW-1:0] ram_addr_in;
    logic          ram_read_en1;
    logic [AW-1:0] ram_addr_out_1;
    logic [BW-1:0] ram_data_out1;
    logic          ram_read_en2;
    logic [AW-1:0] ram_addr_out_2;
    logic [BW-1:0] ram_data_out2;
    logic          op_valid;
    logic          op_ready;
    logic [BW-1:0] op_data1;
    logic [BW-1:0] op_data2;
    logic [TW-1:0] op_tag;

    ram_operand_fetch #(.BW(BW), .AW(AW), .TW(TW), .OUT_DEPTH(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr1      (req_addr1),
        .req_addr2      (req_addr2),
        .req_tag        (req_tag),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .ram_write_en   (ram_write_en),
        .ram_data_in    (ram_data_in),
        .ram_addr_in    (ram_addr_in),
        .ram_read_en1   (ram_read_en1),
        .ram_addr_out_1 (ram_addr_out_1),
        .ram_data_out1  (ram_data_out1),
        .ram_read_en2   (ram_read_en2),
        .ram_addr_out_2 (ram_addr_out_2),
        .ram_data_out2  (ram_data_out2),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_data1       (op_data1),
        .op_data2       (op_data2),
        .op_tag         (op_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous reads, read-before-write on collision
    logic [BW-1:0] ram_mem [NW];
    always @(posedge clk) begin
        if (ram_read_en1) ram_data_out1 <= ram_mem[ram_addr_out_1];
        if (ram_read_en2) ram_data_out2 <= ram_mem[ram_addr_out_2];
        if (ram_write_en) ram_mem[ram_addr_in] <= ram_data_in;
    end

    // Reference model and scoreboard state
    typedef struct {
        logic [BW-1:0] d1;
        logic [BW-1:0] d2;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    logic [BW-1:0] model_mem [NW];
    exp_t          exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            pop_cnt  = 0;
    int            run_len  = 0;
    int            max_run  = 0;
    logic [BW-1:0] last_d1;
    logic [BW-1:0] last_d2;
    logic [TW-1:0] last_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: predicts handshake/latency from outstanding count, compares head
    always @(negedge clk) begin : monitor
        logic exp_ready;
        logic exp_acc;
        logic exp_valid;
        exp_t e;
        chk("wr_en", 32'(ram_write_en), 32'(wb_en));
        if (wb_en) begin
            chk("wr_addr", 32'(ram_addr_in), 32'(wb_addr));
            chk("wr_data", ram_data_in, wb_data);
        end
        if (!rst_n) begin
            exp_q.delete();
            run_len = 0;
            chk("rst_op_valid", 32'(op_valid), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rd_en1", 32'(ram_read_en1), 32'd0);
            chk("rst_rd_en2", 32'(ram_read_en2), 32'd0);
        end else begin
            exp_ready = (exp_q.size() < 3);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            exp_acc = req_valid && exp_ready;
            chk("rd_en1", 32'(ram_read_en1), 32'(exp_acc));
            chk("rd_en2", 32'(ram_read_en2), 32'(exp_acc));
            if (exp_acc) begin
                chk("rd_addr1", 32'(ram_addr_out_1), 32'(req_addr1));
                chk("rd_addr2", 32'(ram_addr_out_2), 32'(req_addr2));
            end
            exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
            chk("op_valid", 32'(op_valid), 32'(exp_valid));
            if (op_valid && exp_valid) begin
                chk("op_data1", op_data1, exp_q[0].d1);
                chk("op_data2", op_data2, exp_q[0].d2);
                chk("op_tag", 32'(op_tag), 32'(exp_q[0].tag));
                if (op_ready) begin
                    last_d1  = op_data1;
                    last_d2  = op_data2;
                    last_tag = op_tag;
                    void'(exp_q.pop_front());
                    pop_cnt++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
            end else begin
                run_len = 0;
            end
            if (exp_acc) begin
                // Operand = memory after every write up to and including this cycle
                e.d1  = (wb_en && wb_addr == req_addr1) ? wb_data : model_mem[req_addr1];
                e.d2  = (wb_en && wb_addr == req_addr2) ? wb_data : model_mem[req_addr2];
                e.tag = req_tag;
                e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
        if (wb_en) model_mem[wb_addr] = wb_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [BW-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [TW-1:0] t);
        logic got;
        got = 1'b0;
        req_valid = 1'b1; req_addr1 = a1; req_addr2 = a2; req_tag = t;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 200 && pop_cnt < target; i++) step();
        chk("pop_timeout", 32'(pop_cnt >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p0;
        logic got;
        rst_n = 1'b0; req_valid = 1'b0; req_addr1 = '0; req_addr2 = '0; req_tag = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b0;
        // Clear the RAM through the pass-through write port while in reset
        step();
        for (int i = 0; i < int'(NW); i++) wb(AW'(i), '0);
        chk("rst_op_data1", op_data1, '0);
        chk("rst_op_data2", op_data2, '0);
        chk("rst_op_tag", 32'(op_tag), 32'd0);
        chk("rst_req_ready_d", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic read with exact two-cycle latency
        wb(AW'(1), 32'hFFFF_FFFF);
        op_ready = 1'b1;
        req_valid = 1'b1; req_addr1 = AW'(1); req_addr2 = AW'(0); req_tag = TW'(3);
        step();
        req_valid = 1'b0;
        chk("basic_valid_n1", 32'(op_valid), 32'd0);
        step();
        chk("basic_valid_n2", 32'(op_valid), 32'd1);
        chk("basic_d1", op_data1, 32'hFFFF_FFFF);
        chk("basic_d2", op_data2, 32'h0);
        chk("basic_tag", 32'(op_tag), 32'd3);
        idle(2);

        // Forwarding in the accept cycle
        wb(AW'(2), 32'h1111_1111);
        p0 = pop_cnt;
        wb_en = 1'b1; wb_addr = AW'(2); wb_data = 32'hDDDD_DDDD;
        send(AW'(2), AW'(2), TW'(5));
        wb_en = 1'b0;
        wait_pops(p0 + 1);
        chk("fwd_d1", last_d1, 32'hDDDD_DDDD);
        chk("fwd_d2", last_d2, 32'hDDDD_DDDD);

        // Write in the capture cycle is not reflected
        wb(AW'(2), 32'h2222_2222);
        p0 = pop_cnt;
        send(AW'(2), AW'(2), TW'(6));
        wb(AW'(2), 32'hDDDD_DDDD);
        wait_pops(p0 + 1);
        chk("late_d1", last_d1, 32'h2222_2222);
        chk("late_d2", last_d2, 32'h2222_2222);
        idle(2);

        // Back-pressure: only three requests outstanding
        op_ready = 1'b0;
        p0 = pop_cnt;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_tag = TW'(k);
            req_addr1 = AW'(k + 8); req_addr2 = AW'(k + 16);
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
            if (got) k++;
        end
        chk("bp_accepted", 32'(k), 32'd3);
        chk("bp_hold_valid", 32'(op_valid), 32'd1);
        chk("bp_hold_tag", 32'(op_tag), 32'd0);
        op_ready = 1'b1;
        for (int c = 0; c < 50 && k < 5; c++) begin
            req_valid = 1'b1; req_tag = TW'(k);
            req_addr1 = AW'(k + 8); req_addr2 = AW'(k + 16);
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
            if (got) k++;
        end
        req_valid = 1'b0;
        wait_pops(p0 + 5);
        chk("bp_last_tag", 32'(last_tag), 32'd4);

        // Throughput: eight back-to-back requests with op_ready high
        for (int i = 0; i < 8; i++) wb(AW'(i), BW'(i));
        idle(2);
        max_run = 0;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr1 = AW'(i); req_addr2 = AW'(7 - i); req_tag = TW'(i);
            @(negedge clk);
            chk("tp_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_pops(p0 + 8);
        idle(1);
        chk("tp_run", 32'(max_run), 32'd8);
        chk("tp_last_d1", last_d1, 32'd7);
        chk("tp_last_d2", last_d2, 32'd0);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr1 = AW'($urandom_range(0, 31));
            req_addr2 = ($urandom_range(0, 3) == 0) ? req_addr1 : AW'($urandom_range(0, 31));
            req_tag   = TW'($urandom_range(0, 15));
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = ($urandom_range(0, 2) == 0) ? req_addr1 : AW'($urandom_range(0, 31));
            wb_data   = $urandom;
            op_ready  = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = 1'b0; wb_en = 1'b0; op_ready = 1'b1;
        idle(8);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two entries buffered and S1 occupied
        op_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr1 = AW'(i); req_addr2 = AW'(i + 1); req_tag = TW'(7 + i);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_op_valid", 32'(op_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_rd_en1", 32'(ram_read_en1), 32'd0);
        chk("midrst_rd_en2", 32'(ram_read_en2), 32'd0);
        req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        op_ready = 1'b1;
        p0 = pop_cnt;
        idle(6);
        chk("post_rst_no_pop", 32'(pop_cnt), 32'(p0));
        wb(AW'(5), 32'h5A5A_5A5A);
        send(AW'(5), AW'(1), TW'(11));
        wait_pops(p0 + 1);
        chk("post_rst_d1", last_d1, 32'h5A5A_5A5A);
        chk("post_rst_tag", 32'(last_tag), 32'd11);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
